// File: rtl/pipe_elastic_reg_pkg.sv
// pipe_elastic_reg_pkg: occupancy encoding and shared constants for the elastic stage
package pipe_elastic_reg_pkg;
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
endpackage

// File: rtl/pipe_elastic_reg_sat_counter.sv
// sat_counter: enable-gated saturating up-counter
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (rdy && inc && cnt != '1) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/pipe_elastic_reg.sv
// pipe_elastic_reg: valid/ready pipeline stage with optional skid slot, flush and stall counter
module pipe_elastic_reg
  import pipe_elastic_reg_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SKID        = 1,
  parameter int BUBBLE_ZERO = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles
);
  occ_e             occ_q, occ_d;
  logic             valid_q, in_rdy_q, in_rdy_d;
  logic [WIDTH-1:0] head_q, head_d, head_n, tail_q, tail_d;
  logic             push, pop, fill, drain;
  assign in_ready  = (SKID != 0) ? in_rdy_q : (~valid_q | out_ready);
  assign out_valid = valid_q;
  assign out_data  = head_q;
  assign occupancy = occ_q;
  always_comb begin
    push     = in_valid & in_ready & rdy & ~flush;
    pop      = out_valid & out_ready & rdy;
    fill     = push & ~pop;
    drain    = pop & ~push;
    occ_d    = flush ? OCC_EMPTY
             : fill  ? ((occ_q == OCC_EMPTY) ? OCC_ONE : OCC_FULL)
             : drain ? ((occ_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY)
             : occ_q;
    head_n   = flush ? head_q
             : (push && (occ_q == OCC_EMPTY || pop)) ? in_data
             : (pop && occ_q == OCC_FULL) ? tail_q
             : head_q;
    head_d   = (BUBBLE_ZERO != 0 && occ_d == OCC_EMPTY) ? '0 : head_n;
    tail_d   = (fill && occ_q == OCC_ONE) ? in_data : tail_q;
    in_rdy_d = occ_d != OCC_FULL;
  end
  always_ff @(posedge clk)
    if (rst) begin
      occ_q    <= OCC_EMPTY;
      valid_q  <= DISABLE;
      head_q   <= '0;
      tail_q   <= '0;
      in_rdy_q <= ENABLE;
    end else if (rdy) begin
      occ_q    <= occ_d;
      valid_q  <= occ_d != OCC_EMPTY;
      head_q   <= head_d;
      tail_q   <= tail_d;
      in_rdy_q <= in_rdy_d;
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cycles)
  );
endmodule
